// File: rtl/inst_fetch_bridge.sv
// Instruction fetch bridge: line buffer (64-bit pairs) filled by two word reads.
// Define IFB_PREFETCH_EN to add a second entry and a sequential next-line prefetch.
module inst_fetch_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_addr_in,
  output logic [63:0] inst_out,
  output logic        stop_out,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data
);

  localparam logic [63:0] NOP_PAIR = 64'h00000013_00000013;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4
  } state_t;

  state_t      state_r;
  logic        a_valid_r;
  logic [28:0] a_tag_r;
  logic [63:0] a_data_r;
  logic [28:0] fill_tag_r;
  logic [31:0] hi_word_r;
  logic        req_valid_r;
  logic [31:0] req_addr_r;

  logic [28:0] cur_tag_s;
  logic [2:0]  unused_ofs_s;
  logic        hit_a_s;
  logic        hit_s;
  logic [63:0] hit_data_s;

`ifdef IFB_PREFETCH_EN
  logic        b_valid_r;
  logic [28:0] b_tag_r;
  logic [63:0] b_data_r;
  logic        fill_b_r;
  logic        pf_pend_r;
  logic [28:0] pf_tag_r;
  logic        hit_b_s;
  logic        pf_present_s;
`endif

  assign cur_tag_s    = inst_addr_in[31:3];
  assign unused_ofs_s = inst_addr_in[2:0];

  // Combinational hit check; entry A wins over entry B.
  always_comb begin
    hit_a_s    = a_valid_r && (a_tag_r == cur_tag_s);
    hit_s      = 1'b0;
    hit_data_s = NOP_PAIR;
`ifdef IFB_PREFETCH_EN
    hit_b_s      = b_valid_r && (b_tag_r == cur_tag_s);
    pf_present_s = (a_valid_r && (a_tag_r == pf_tag_r)) ||
                   (b_valid_r && (b_tag_r == pf_tag_r));
    if (hit_a_s) begin
      hit_s      = 1'b1;
      hit_data_s = a_data_r;
    end else if (hit_b_s) begin
      hit_s      = 1'b1;
      hit_data_s = b_data_r;
    end else begin
      hit_s      = 1'b0;
      hit_data_s = NOP_PAIR;
    end
`else
    if (hit_a_s) begin
      hit_s      = 1'b1;
      hit_data_s = a_data_r;
    end else begin
      hit_s      = 1'b0;
      hit_data_s = NOP_PAIR;
    end
`endif
  end

  // IF stage must see hit data in the same cycle, so these stay combinational.
  always_comb begin
    stop_out      = !hit_s;
    inst_out      = hit_data_s;
    mem_req_valid = req_valid_r;
    mem_req_addr  = req_addr_r;
  end

  // Fill FSM; request valid/address are registered and held until accepted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= IDLE;
      a_valid_r   <= 1'b0;
      req_valid_r <= 1'b0;
      req_addr_r  <= 32'h0000_0000;
      fill_tag_r  <= 29'd0;
      hi_word_r   <= 32'h0000_0000;
`ifdef IFB_PREFETCH_EN
      b_valid_r   <= 1'b0;
      fill_b_r    <= 1'b0;
      pf_pend_r   <= 1'b0;
      pf_tag_r    <= 29'd0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (!hit_s) begin
            fill_tag_r  <= cur_tag_s;
            req_valid_r <= 1'b1;
            req_addr_r  <= {cur_tag_s, 3'b000};
            state_r     <= REQ0;
`ifdef IFB_PREFETCH_EN
            fill_b_r    <= 1'b0;
`endif
          end
`ifdef IFB_PREFETCH_EN
          else if (pf_pend_r) begin
            pf_pend_r <= 1'b0;
            if (!pf_present_s) begin
              fill_tag_r  <= pf_tag_r;
              fill_b_r    <= 1'b1;
              req_valid_r <= 1'b1;
              req_addr_r  <= {pf_tag_r, 3'b000};
              state_r     <= REQ0;
            end else begin
              state_r <= IDLE;
            end
          end
`endif
          else begin
            state_r <= IDLE;
          end
        end
        REQ0: begin
          if (mem_req_ready) begin
            req_valid_r <= 1'b0;
            state_r     <= WAIT0;
          end else begin
            state_r <= REQ0;
          end
        end
        WAIT0: begin
          if (mem_rsp_valid) begin
            hi_word_r   <= mem_rsp_data;
            req_valid_r <= 1'b1;
            req_addr_r  <= {fill_tag_r, 3'b100};
            state_r     <= REQ1;
          end else begin
            state_r <= WAIT0;
          end
        end
        REQ1: begin
          if (mem_req_ready) begin
            req_valid_r <= 1'b0;
            state_r     <= WAIT1;
          end else begin
            state_r <= REQ1;
          end
        end
        WAIT1: begin
          if (mem_rsp_valid) begin
`ifdef IFB_PREFETCH_EN
            if (fill_b_r) begin
              b_valid_r <= 1'b1;
              b_tag_r   <= fill_tag_r;
              b_data_r  <= {hi_word_r, mem_rsp_data};
            end else begin
              a_valid_r <= 1'b1;
              a_tag_r   <= fill_tag_r;
              a_data_r  <= {hi_word_r, mem_rsp_data};
              pf_pend_r <= 1'b1;
              pf_tag_r  <= fill_tag_r + 29'd1;
            end
`else
            a_valid_r <= 1'b1;
            a_tag_r   <= fill_tag_r;
            a_data_r  <= {hi_word_r, mem_rsp_data};
`endif
            state_r <= IDLE;
          end else begin
            state_r <= WAIT1;
          end
        end
        default: begin
          req_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule
